// File: rtl/ahb_copy_dma.sv
// AHB-Lite master that copies a block of 32-bit words between RAM regions,
// using one non-pipelined word read followed by one word write per element.
module ahb_copy_dma #(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] word_count,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [31:0]          HWDATA,
  input  logic                 HREADY,
  input  logic [31:0]          HRDATA
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRdA  = 3'd1;
  localparam logic [2:0] StRdD  = 3'd2;
  localparam logic [2:0] StWrA  = 3'd3;
  localparam logic [2:0] StWrD  = 3'd4;

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  logic [2:0]           state_q, state_d;
  logic [31:0]          src_ptr_q, src_ptr_d;
  logic [31:0]          dst_ptr_q, dst_ptr_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [31:0]          buffer_q, buffer_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    buffer_d    = buffer_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (word_count != '0) begin
            src_ptr_d   = {src_addr[31:2], 2'b00};
            dst_ptr_d   = {dst_addr[31:2], 2'b00};
            remaining_d = word_count;
            state_d     = StRdA;
          end else begin
            // Empty copy: report completion without touching the bus.
            done_d = 1'b1;
          end
        end
      end
      StRdA: begin
        if (HREADY) state_d = StRdD;
      end
      StRdD: begin
        if (HREADY) begin
          buffer_d = HRDATA;
          state_d  = StWrA;
        end
      end
      StWrA: begin
        if (HREADY) state_d = StWrD;
      end
      StWrD: begin
        if (HREADY) begin
          src_ptr_d   = src_ptr_q + 32'd4;
          dst_ptr_d   = dst_ptr_q + 32'd4;
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StRdA;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      buffer_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      buffer_q    <= buffer_d;
      done_q      <= done_d;
    end
  end

  // Bus outputs depend only on registered state, so they stay stable while HREADY is low.
  always_comb begin
    HADDR  = 32'h0;
    HTRANS = TransIdle;
    HWRITE = 1'b0;
    HWDATA = 32'h0;
    case (state_q)
      StRdA: begin
        HADDR  = src_ptr_q;
        HTRANS = TransNonseq;
      end
      StRdD: begin
        HADDR = src_ptr_q;
      end
      StWrA: begin
        HADDR  = dst_ptr_q;
        HTRANS = TransNonseq;
        HWRITE = 1'b1;
      end
      StWrD: begin
        HADDR  = dst_ptr_q;
        HWRITE = 1'b1;
        HWDATA = buffer_q;
      end
      default: begin
        HADDR  = 32'h0;
        HTRANS = TransIdle;
      end
    endcase
  end

  assign HSIZE = 3'b010;
  assign busy  = (state_q != StIdle);
  assign done  = done_q;

endmodule

// File: tb/tb_ahb_copy_dma.sv
// Self-checking bench for ahb_copy_dma: AHB RAM slave with wait-state injection,
// table-driven and randomized copies checked against a block-copy reference model.
module tb_ahb_copy_dma;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] word_count;
  logic        busy, done;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;

  ahb_copy_dma #(.LEN_WIDTH(16)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRDATA     (HRDATA)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  // 4 KB RAM, word-indexed by address bits [11:2]
  logic [31:0] mem [1024];

  typedef struct {
    logic [31:0] addr;
    logic        wr;
  } xfer_t;
  xfer_t log_q[$];

  logic        dp_valid, dp_write;
  logic [31:0] dp_addr;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 32'h0;
    end else if (HREADY) begin
      if (dp_valid && dp_write) mem[dp_addr[11:2]] = HWDATA;
      dp_valid <= (HTRANS == 2'b10);
      dp_addr  <= HADDR;
      dp_write <= HWRITE;
      if (HTRANS == 2'b10) log_q.push_back('{addr: HADDR, wr: HWRITE});
    end
  end

  assign HRDATA = (dp_valid && !dp_write) ? mem[dp_addr[11:2]] : 32'h0;

  bit stall [512];
  bit hold_check;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 512; i++) stall[i] = 1'b0;
  endtask

  task automatic random_stalls();
    for (int i = 0; i < 512; i++) stall[i] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic preload();
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
  endtask

  // Runs one copy; reference: ascending word-by-word copy, one read then one write per word,
  // completion one cycle after the 4N-th cycle in which HREADY was high.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int inject_at, output int lat);
    logic [31:0] exp_mem [1024];
    xfer_t       exp_log[$];
    logic [31:0] sa, da, ra, wa, first_word;
    int          exp_lat, ready_cnt, cyc;
    bit          window_ok;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    exp_mem = mem;
    first_word = mem[sa[11:2]];
    for (int i = 0; i < n; i++) begin
      ra = sa + 32'(4 * i);
      wa = da + 32'(4 * i);
      exp_mem[wa[11:2]] = exp_mem[ra[11:2]];
      exp_log.push_back('{addr: ra, wr: 1'b0});
      exp_log.push_back('{addr: wa, wr: 1'b1});
    end
    exp_lat = 1;
    if (n > 0) begin
      ready_cnt = 0;
      for (int c = 1; c < 512; c++) begin
        if (!stall[c]) ready_cnt++;
        if (ready_cnt == 4 * n) begin
          exp_lat = c + 1;
          break;
        end
      end
    end
    log_q.delete();
    @(negedge HCLK);
    start      = 1'b1;
    src_addr   = s;
    dst_addr   = d;
    word_count = 16'(n);
    HREADY     = !stall[0];
    cyc        = 0;
    lat        = -1;
    window_ok  = 1'b1;
    while (cyc < 2000) begin
      @(negedge HCLK);
      cyc++;
      start = 1'b0;
      if (cyc == inject_at) begin
        start      = 1'b1;
        word_count = 16'd7;
        src_addr   = 32'h0000_0800;
      end
      if (done) begin
        lat = cyc;
        break;
      end
      if (busy !== 1'b1 || !(HTRANS == 2'b00 || HTRANS == 2'b10) || HSIZE !== 3'b010)
        window_ok = 1'b0;
      if (hold_check && cyc >= 1 && cyc <= 3) begin
        check("hold_rd_haddr", HADDR, sa);
        check("hold_rd_htrans", HTRANS, 2'b10);
        check("hold_rd_hwdata", HWDATA, 32'h0);
      end
      if (hold_check && cyc >= 7 && cyc <= 9) begin
        check("hold_wr_haddr", HADDR, da);
        check("hold_wr_htrans", HTRANS, 2'b00);
        check("hold_wr_hwdata", HWDATA, first_word);
      end
      HREADY = (cyc < 512) ? !stall[cyc] : 1'b1;
    end
    start  = 1'b0;
    HREADY = 1'b1;
    check("latency_model", 64'(lat), 64'(exp_lat));
    check("busy_window", {63'h0, window_ok}, 64'h1);
    check("busy_at_done", {63'h0, busy}, 64'h0);
    begin
      int bad;
      bad = -1;
      for (int i = 0; i < 1024; i++)
        if (mem[i] !== exp_mem[i] && bad < 0) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL mem_contents: word %0d got %h expected %h", bad, mem[bad], exp_mem[bad]);
      end
    end
    begin
      bit log_ok;
      log_ok = (log_q.size() == exp_log.size());
      for (int i = 0; i < exp_log.size() && log_ok; i++)
        if (log_q[i].addr !== exp_log[i].addr || log_q[i].wr !== exp_log[i].wr) log_ok = 1'b0;
      checks++;
      if (!log_ok) begin
        errors++;
        $display("FAIL bus_log: got %0d transfers expected %0d (order/address differ)",
                 log_q.size(), exp_log.size());
      end
    end
    @(negedge HCLK);
    check("done_pulse_width", {63'h0, done}, 64'h0);
    check("idle_htrans", HTRANS, 2'b00);
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          n;
    int          lat;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int lat;
    vecs[0] = '{src: 32'h0000_0000, dst: 32'h0000_0100, n: 4, lat: 17};
    vecs[1] = '{src: 32'h0000_0203, dst: 32'h0000_0302, n: 2, lat: 9};
    vecs[2] = '{src: 32'hFFFF_FFFC, dst: 32'h0000_0400, n: 2, lat: 9};
    vecs[3] = '{src: 32'h0000_0000, dst: 32'h0000_0000, n: 0, lat: 1};
    vecs[4] = '{src: 32'h0000_0040, dst: 32'h0000_0048, n: 5, lat: 21};
    vecs[5] = '{src: 32'h0000_0080, dst: 32'h0000_0078, n: 3, lat: 13};

    HRESETn    = 1'b0;
    start      = 1'b0;
    src_addr   = 32'h0;
    dst_addr   = 32'h0;
    word_count = 16'h0;
    HREADY     = 1'b1;
    hold_check = 1'b0;
    preload();
    clear_stalls();
    repeat (2) @(negedge HCLK);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    for (int i = 0; i < 6; i++) begin
      run_copy(vecs[i].src, vecs[i].dst, vecs[i].n, -1, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      if (i == 2) check("wrap_2nd_read", log_q[2].addr, 32'h0);
      if (i == 1) check("align_1st_read", log_q[0].addr, 32'h0000_0200);
    end

    // Wait states: 3 cycles in the first read address phase and the first write data phase.
    clear_stalls();
    stall[1] = 1'b1; stall[2] = 1'b1; stall[3] = 1'b1;
    stall[7] = 1'b1; stall[8] = 1'b1; stall[9] = 1'b1;
    hold_check = 1'b1;
    run_copy(32'h0000_0010, 32'h0000_0110, 2, -1, lat);
    hold_check = 1'b0;
    check("stall_latency", 64'(lat), 64'd15);
    clear_stalls();

    // Start while busy must not restart or extend the copy.
    run_copy(32'h0000_0020, 32'h0000_0120, 3, 5, lat);
    check("busy_start_latency", 64'(lat), 64'd13);

    // Reset during the write address phase of word 2.
    @(negedge HCLK);
    start      = 1'b1;
    src_addr   = 32'h0000_0500;
    dst_addr   = 32'h0000_0600;
    word_count = 16'd3;
    for (int c = 1; c <= 7; c++) begin
      @(negedge HCLK);
      start = 1'b0;
    end
    check("pre_rst_wr_addr", HADDR, 32'h0000_0604);
    check("pre_rst_htrans", HTRANS, 2'b10);
    HRESETn = 1'b0;
    #1;
    check("mid_rst_busy", {63'h0, busy}, 64'h0);
    check("mid_rst_htrans", HTRANS, 2'b00);
    check("mid_rst_haddr", HADDR, 32'h0);
    check("mid_rst_hwrite", {63'h0, HWRITE}, 64'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    run_copy(32'h0000_0500, 32'h0000_0600, 3, -1, lat);
    check("post_rst_latency", 64'(lat), 64'd13);

    // Randomized copies with random wait states.
    for (int k = 0; k < 8; k++) begin
      logic [31:0] s, d;
      preload();
      random_stalls();
      s = 32'($urandom_range(0, 1023)) << 2;
      d = 32'($urandom_range(0, 1023)) << 2;
      run_copy(s | 32'($urandom_range(0, 3)), d, $urandom_range(1, 8), -1, lat);
    end
    clear_stalls();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
